// File: rtl/rcv_block_fifo_param.sv
// Receive FIFO: packs WORD_W-bit words into WORDS_PER_BLK-word blocks, holds DEPTH
// blocks, and tracks occupancy, partial fill, overflow/underflow and framing errors.
module rcv_block_fifo_param #(
    parameter int WORD_W        = 32,
    parameter int WORDS_PER_BLK = 4,
    parameter int DEPTH         = 4
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic [WORD_W-1:0]                 wr_data,
    input  logic                              enq_word,
    input  logic                              deq,
    input  logic                              fix_error,
    input  logic                              flush,
    output logic [WORD_W*WORDS_PER_BLK-1:0]   rd_data,
    output logic                              full,
    output logic                              empty,
    output logic                              framing_error,
    output logic [$clog2(DEPTH):0]            blk_count,
    output logic [$clog2(WORDS_PER_BLK)-1:0]  partial_words,
    output logic                              overflow,
    output logic                              underflow
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int WPW   = $clog2(WORDS_PER_BLK);
    localparam int BLK_W = WORD_W * WORDS_PER_BLK;

    typedef enum logic [1:0] {IDLE, FILL, ERR} state_t;

    logic [BLK_W-1:0] mem [DEPTH];
    logic [PW-1:0]    head, tail;
    state_t           state;
    logic             last_word, err_hit, deq_ok, enq_ok, commit;

    assign full      = (blk_count == CW'(DEPTH));
    assign empty     = (blk_count == '0);
    assign rd_data   = empty ? '0 : mem[head];
    assign last_word = (partial_words == WPW'(WORDS_PER_BLK - 1));

    // A consumer pulling while a block is half-built means the sender stalled mid-block.
    always_comb begin
        err_hit = (state == FILL) && deq && empty;
        deq_ok  = deq && !empty;
        enq_ok  = enq_word && !full && (state != ERR) && !err_hit;
        commit  = enq_ok && last_word;
    end

    // Words land straight in the tail slot; it only becomes visible once committed.
    always_ff @(posedge clk) begin
        if (n_rst && !flush && !fix_error && enq_ok)
            mem[tail][partial_words*WORD_W +: WORD_W] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!n_rst || flush) begin
            head          <= '0;
            tail          <= '0;
            blk_count     <= '0;
            partial_words <= '0;
            framing_error <= 1'b0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
            state         <= IDLE;
        end else if (fix_error) begin
            partial_words <= '0;
            framing_error <= 1'b0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
            state         <= IDLE;
        end else begin
            overflow  <= enq_word && full && (state != ERR);
            underflow <= deq && empty;
            if (err_hit) begin
                state         <= ERR;
                framing_error <= 1'b1;
            end
            if (deq_ok)
                head <= head + 1'b1;
            if (enq_ok) begin
                if (last_word) begin
                    partial_words <= '0;
                    tail          <= tail + 1'b1;
                    state         <= IDLE;
                end else begin
                    partial_words <= partial_words + 1'b1;
                    state         <= FILL;
                end
            end
            if (commit && !deq_ok)
                blk_count <= blk_count + CW'(1);
            else if (deq_ok && !commit)
                blk_count <= blk_count - CW'(1);
        end
    end
endmodule

// File: doc/rcv_block_fifo_param.md
Name: rcv_block_fifo_param

Overview:
- Parametrised receive FIFO. Packs WORD_W-bit bus words, written one per cycle, into blocks of WORDS_PER_BLK words, and stores DEPTH blocks for the downstream block consumer.
- Next generation of the fixed 32-bit × 4-word × 4-deep receive FIFO.
- Adds occupancy count, partial-word count, overflow/underflow pulses, synchronous flush, and a sticky framing-error FSM with explicit recovery.

Parameters:
- WORD_W, 32, width of one input word.
- WORDS_PER_BLK, 4, words per block; must be ≥2.
- DEPTH, 4, block entries; must be a power of 2 and ≥2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- n_rst  in  1  reset, synchronous and active-low (sampled on rising edge of clk).
- wr_data  in  WORD_W  input word.
- enq_word  in  1  write wr_data into the current block this cycle.
- deq  in  1  pop the head block this cycle.
- fix_error  in  1  clear framing error and discard the partial block.
- flush  in  1  synchronous clear of all FIFO contents and state.
- rd_data  out  WORD_W*WORDS_PER_BLK  head block, first-word-fall-through.
- full  out  1  blk_count == DEPTH.
- empty  out  1  blk_count == 0.
- framing_error  out  1  sticky error flag.
- blk_count  out  $clog2(DEPTH)+1  committed blocks stored.
- partial_words  out  $clog2(WORDS_PER_BLK)  words staged in the block being built.
- overflow  out  1  one-cycle pulse, word rejected.
- underflow  out  1  one-cycle pulse, deq while empty.

Behaviour:
- Reset (n_rst=0 at a clock edge): head, tail, blk_count, partial_words, framing_error, overflow, underflow are cleared; empty=1; full=0; FSM goes to IDLE. Memory is not reset.
- Packing: word k of a block (k = 0..WORDS_PER_BLK-1, in arrival order) occupies rd_data[k*WORD_W +: WORD_W]. Word 0 is in the LSBs.
- Words are written directly into mem[tail] at slice partial_words; there is no separate staging register.
- Accepted enq_word increments partial_words.
- On the last word (partial_words == WORDS_PER_BLK-1): partial_words wraps to 0, tail increments modulo DEPTH, and blk_count increments.
- Latency: the completed block is visible on rd_data, and empty falls, in the cycle after the edge that accepted its last word.
- rd_data = mem[head] combinationally; it is all-zero when empty=1.
- deq with empty=0: head increments modulo DEPTH and blk_count decrements at the edge.
- deq with empty=1: no state change; underflow pulses high for the next cycle.
- Full:
  - Any enq_word while full=1 is rejected (the word is dropped) and overflow pulses, even if deq is asserted in the same cycle.
  - The deq still takes effect.
- Simultaneous completing enq_word and valid deq (not full): both take effect; blk_count is unchanged.
- FSM states:
  - IDLE (partial_words == 0, no error): accepted enq_word → FILL, or stays in IDLE when WORDS_PER_BLK words complete immediately (not possible since WORDS_PER_BLK ≥ 2).
  - FILL (partial_words > 0): the last word → IDLE.
  - FILL: deq while empty=1 (consumer expects a block but the sender stopped mid-block) → ERR, framing_error=1 from the next cycle; underflow also pulses.
  - ERR: enq_word ignored (no overflow pulse); deq of committed blocks still allowed.
  - ERR: fix_error → IDLE; partial_words cleared, framing_error cleared next cycle.
  - fix_error outside ERR: discards any partial words → IDLE; no other effect.
- flush: has the same effect as reset on all state and outputs. Priority: n_rst > flush > fix_error > enq/deq. enq/deq in the flush cycle are ignored.
- Reset or flush mid-block discards the partial block; committed blocks are lost.
- Pointer arithmetic: $clog2(DEPTH)-bit pointers wrap naturally. full/empty are derived from blk_count, not from pointer compare.

Test Plan:
- Defaults. Reset, then enq 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles → next cycle rd_data=0x44444444_33333333_22222222_11111111, empty=0, blk_count=1; deq → empty=1, rd_data=0.
- Fill 4 blocks → full=1, blk_count=4. 5th-block enq_word → overflow pulse, blk_count stays 4. Enq concurrent with deq → deq honoured, word still rejected, blk_count=3.
- Enq 2 words (partial_words=2), then deq with empty=1 → underflow pulse, framing_error=1. Further enq ignored (partial_words stays 2). fix_error → framing_error=0, partial_words=0. A fresh 4-word block then reads back correctly.
- With one block stored, enq its successor's last word and deq in the same cycle → blk_count stays 1, rd_data shows the new block.
- Wrap-around: push/pop 10 blocks with incrementing data through the depth-4 FIFO → in-order data, blk_count never exceeds 4.
- flush with 2 blocks plus 3 partial words → next cycle empty=1, blk_count=0, partial_words=0. n_rst low mid-block gives the same result. Re-run with WORD_W=16, WORDS_PER_BLK=8, DEPTH=8.
